// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: frame format shared by the UART frame receiver and transmitter.
package uart_frame_pkg;
    localparam logic [7:0] HDR = 8'hA5;
    localparam int FRAME_LEN = 7;
    localparam int POS_W = 11;
    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECKSUM} rx_state_t;
endpackage

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: parses 7-byte position frames, validates checksum/range, tracks link liveness.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int BYTE_TIMEOUT = 65000,
    parameter int LINK_TIMEOUT = 6500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [POS_W-1:0] remote_x,
    output logic [POS_W-1:0] remote_y,
    output logic [7:0]       remote_state,
    output logic             frame_ok,
    output logic             frame_err,
    output logic [7:0]       err_count,
    output logic             link_alive
);
    localparam int BT_W = $clog2(BYTE_TIMEOUT + 1);
    localparam int LT_W = $clog2(LINK_TIMEOUT + 1);

    rx_state_t state, state_nx;
    logic [2:0] idx, idx_nx;
    logic [7:0] acc, acc_nx;
    logic [7:0] payload [FRAME_LEN-2];
    logic [BT_W-1:0] byte_timer;
    logic [LT_W-1:0] link_timer;
    logic timeout, accept, reject;

    // A byte arriving on the expiry cycle keeps the frame alive.
    assign timeout = state != IDLE && !rx_valid && byte_timer == BT_W'(BYTE_TIMEOUT - 1);
    assign accept = state == CHECKSUM && rx_valid && rx_data == acc
                    && payload[0][7:3] == 5'd0 && payload[2][7:3] == 5'd0;
    assign reject = (state == CHECKSUM && rx_valid && !accept) || timeout;

    always_comb begin
        state_nx = state;
        idx_nx = idx;
        acc_nx = acc;
        case (state)
            IDLE: if (rx_valid && rx_data == HDR) begin
                state_nx = PAYLOAD;
                idx_nx = '0;
                acc_nx = '0;
            end
            PAYLOAD: if (rx_valid) begin
                acc_nx = acc ^ rx_data;
                idx_nx = idx + 3'd1;
                state_nx = (idx == 3'(FRAME_LEN - 3)) ? CHECKSUM : PAYLOAD;
            end
            CHECKSUM: if (rx_valid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (timeout) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            acc <= '0;
            byte_timer <= '0;
            link_timer <= '0;
            remote_x <= '0;
            remote_y <= '0;
            remote_state <= '0;
            frame_ok <= 1'b0;
            frame_err <= 1'b0;
            err_count <= '0;
            link_alive <= 1'b0;
        end else begin
            state <= state_nx;
            idx <= idx_nx;
            acc <= acc_nx;
            byte_timer <= (rx_valid || state == IDLE || timeout) ? '0 : byte_timer + BT_W'(1);
            frame_ok <= accept;
            frame_err <= reject;
            if (reject && err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (accept) begin
                remote_x <= {payload[0][2:0], payload[1]};
                remote_y <= {payload[2][2:0], payload[3]};
                remote_state <= payload[4];
                link_timer <= '0;
                link_alive <= 1'b1;
            end else begin
                if (link_timer != LT_W'(LINK_TIMEOUT)) link_timer <= link_timer + LT_W'(1);
                if (link_timer == LT_W'(LINK_TIMEOUT - 1)) link_alive <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == PAYLOAD && rx_valid) payload[idx] <= rx_data;
    end
endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: random and directed frames checked cycle by cycle against a frame-level model.
module tb_uart_frame_rx;
    import uart_frame_pkg::*;
    localparam int BT = 20;
    localparam int LT = 400;

    logic clk = 1'b0, rst = 1'b1, rx_valid = 1'b0;
    logic [7:0] rx_data = '0;
    logic [POS_W-1:0] remote_x, remote_y;
    logic [7:0] remote_state, err_count;
    logic frame_ok, frame_err, link_alive;

    uart_frame_rx #(.BYTE_TIMEOUT(BT), .LINK_TIMEOUT(LT)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .remote_x(remote_x), .remote_y(remote_y), .remote_state(remote_state),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_count(err_count),
        .link_alive(link_alive)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    bit m_in, m_alive;
    logic [7:0] m_q [$];
    int m_idle, m_age;
    logic [10:0] m_x, m_y;
    logic [7:0] m_s, m_cnt;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the frame-level model, then compare all outputs.
    task automatic tick(input bit v, input logic [7:0] d, input bit r = 1'b0);
        bit eo = 1'b0, ee = 1'b0;
        logic [7:0] xr;
        rx_valid = v;
        rx_data = d;
        rst = r;
        if (r) begin
            m_in = 0; m_q.delete(); m_idle = 0; m_age = 0;
            m_x = 0; m_y = 0; m_s = 0; m_cnt = 0; m_alive = 0;
        end else begin
            if (v) begin
                m_idle = 0;
                if (!m_in) begin
                    if (d == HDR) begin m_in = 1; m_q.delete(); end
                end else begin
                    m_q.push_back(d);
                    if (m_q.size() == FRAME_LEN - 1) begin
                        xr = m_q[0] ^ m_q[1] ^ m_q[2] ^ m_q[3] ^ m_q[4];
                        if (xr == m_q[5] && m_q[0] < 8 && m_q[2] < 8) begin
                            eo = 1;
                            m_x = {m_q[0][2:0], m_q[1]};
                            m_y = {m_q[2][2:0], m_q[3]};
                            m_s = m_q[4];
                        end else ee = 1;
                        m_in = 0;
                    end
                end
            end else if (m_in) begin
                m_idle++;
                if (m_idle == BT) begin ee = 1; m_in = 0; m_idle = 0; end
            end
            if (ee && m_cnt != 8'd255) m_cnt++;
            if (eo) begin
                m_age = 0; m_alive = 1;
            end else begin
                if (m_age != LT) m_age++;
                if (m_age == LT) m_alive = 0;
            end
        end
        @(posedge clk);
        #1;
        check("frame_ok", 32'(frame_ok), 32'(eo));
        check("frame_err", 32'(frame_err), 32'(ee));
        check("ok_and_err", 32'(frame_ok & frame_err), 32'd0);
        check("err_count", 32'(err_count), 32'(m_cnt));
        check("link_alive", 32'(link_alive), 32'(m_alive));
        check("remote_x", 32'(remote_x), 32'(m_x));
        check("remote_y", 32'(remote_y), 32'(m_y));
        check("remote_state", 32'(remote_state), 32'(m_s));
        rx_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f [7], input int gap);
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, f[i]);
            repeat (gap) tick(1'b0, 8'h00);
        end
    endtask

    task automatic rand_frame(input int gap_mode);
        logic [7:0] f [7];
        f[0] = HDR;
        f[1] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
        f[2] = 8'($urandom);
        f[3] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
        f[4] = 8'($urandom);
        f[5] = 8'($urandom);
        f[6] = f[1] ^ f[2] ^ f[3] ^ f[4] ^ f[5];
        if ($urandom_range(0, 4) == 0) f[6] = f[6] ^ 8'(1 << $urandom_range(0, 7));
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, f[i]);
            case (gap_mode)
                0: ;
                1: repeat ($urandom_range(0, 3)) tick(1'b0, 8'h00);
                2: repeat (BT - 1) tick(1'b0, 8'h00);
                default: repeat ($urandom_range(BT - 2, BT + 1)) tick(1'b0, 8'h00);
            endcase
        end
    endtask

    initial begin
        logic [7:0] fr [7];
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b1, HDR, 1'b1);
        fr = '{8'hA5, 8'h01, 8'h23, 8'h02, 8'hAB, 8'h05, 8'h8E};
        send_frame(fr, 0);
        check("good_x", 32'(remote_x), 32'h123);
        check("good_y", 32'(remote_y), 32'h2AB);
        check("good_state", 32'(remote_state), 32'h05);
        fr[6] = 8'h8F;
        send_frame(fr, 1);
        fr = '{8'hA5, 8'h09, 8'h23, 8'h02, 8'hAB, 8'h05, 8'h86};
        send_frame(fr, 0);
        tick(1'b1, HDR);
        tick(1'b1, 8'h01);
        repeat (BT) tick(1'b0, 8'h00);
        fr = '{8'hA5, 8'h06, 8'h11, 8'h01, 8'h22, 8'h7E, 8'h00};
        fr[6] = fr[1] ^ fr[2] ^ fr[3] ^ fr[4] ^ fr[5];
        send_frame(fr, BT - 1);
        tick(1'b1, 8'h00);
        tick(1'b1, 8'hFF);
        repeat (7) tick(1'b1, HDR);
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0) tick(1'b1, 8'($urandom));
            rand_frame($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) tick(1'b0, 8'h00);
        end
        fr = '{8'hA5, 8'h01, 8'h23, 8'h02, 8'hAB, 8'h05, 8'h8F};
        repeat (300) send_frame(fr, 0);
        fr = '{8'hA5, 8'h07, 8'hFF, 8'h07, 8'hFF, 8'h3C, 8'h3C};
        send_frame(fr, 0);
        repeat (LT + 10) tick(1'b0, 8'h00);
        fr = '{8'hA5, 8'h01, 8'h23, 8'h02, 8'hAB, 8'h05, 8'h8E};
        send_frame(fr, 0);
        tick(1'b1, HDR);
        tick(1'b1, 8'h01);
        tick(1'b1, 8'h23);
        tick(1'b1, 8'h02, 1'b1);
        tick(1'b1, 8'hAB);
        tick(1'b1, 8'h05);
        tick(1'b1, 8'h8E);
        repeat (BT + 5) tick(1'b0, 8'h00);
        send_frame(fr, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 Parameter BYTE_TIMEOUT, default 65000, max idle clk cycles between bytes inside a frame.
REQ-002 Parameter LINK_TIMEOUT, default 6500000, max clk cycles between good frames before link_alive drops.
REQ-003 clk  in  1  system clock, all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 rx_data  in  8  received byte from UART controller.
REQ-006 rx_valid  in  1  one-cycle strobe, rx_data valid this cycle.
REQ-007 remote_x  out  11  last accepted remote player X position.
REQ-008 remote_y  out  11  last accepted remote player Y position.
REQ-009 remote_state  out  8  last accepted remote player state byte.
REQ-010 frame_ok  out  1  one-cycle pulse, new frame accepted.
REQ-011 frame_err  out  1  one-cycle pulse, frame rejected (checksum, range or timeout).
REQ-012 err_count  out  8  saturating count of frame_err pulses.
REQ-013 link_alive  out  1  high while good frames arrive within LINK_TIMEOUT.

Function
REQ-014 Frame format SHALL be 7 bytes: HDR=0xA5, X_HI, X_LO, Y_HI, Y_LO, STATE, CHK.
REQ-015 CHK SHALL equal XOR of bytes 2..6 (X_HI through STATE); HDR is excluded.
REQ-016 FSM states SHALL be IDLE, PAYLOAD, CHECKSUM.
- IDLE: rx_valid with 0xA5 -> PAYLOAD, index=0, running XOR=0. Other bytes are discarded silently with no error.
- PAYLOAD: each rx_valid stores the byte at index and XORs it in. The 5th byte -> CHECKSUM.
- CHECKSUM: rx_valid -> compare -> IDLE.
REQ-017 0xA5 received in PAYLOAD or CHECKSUM SHALL be treated as data, not as a resync.
REQ-018 Accept condition SHALL be CHK match AND X_HI[7:3]==0 AND Y_HI[7:3]==0.
REQ-019 On accept, outputs SHALL update as follows:
- remote_x={X_HI[2:0],X_LO}, remote_y={Y_HI[2:0],Y_LO}, remote_state=STATE.
- Outputs and frame_ok are registered on the edge after the CHK strobe (latency 1 cycle).
REQ-020 On reject, remote_* SHALL hold their values, and frame_err SHALL pulse 1 cycle after the CHK strobe.
REQ-021 Byte timer SHALL clear on every rx_valid and count while in PAYLOAD/CHECKSUM.
- Reaching BYTE_TIMEOUT -> frame_err pulse, FSM -> IDLE, partial data discarded.
REQ-022 If the timeout and rx_valid occur in the same cycle, rx_valid SHALL win and the timer clears.
REQ-023 err_count SHALL increment on each frame_err and saturate at 255, never wrapping.
REQ-024 Link timer SHALL clear on each frame_ok and increment otherwise, saturating.
- link_alive=1 from the frame_ok cycle until LINK_TIMEOUT cycles elapse without frame_ok.
REQ-025 frame_ok and frame_err SHALL never be high in the same cycle.
REQ-026 The block SHALL impose no backpressure; back-to-back rx_valid on consecutive cycles SHALL be accepted.

Reset
REQ-027 On rst, the following SHALL apply on the next edge:
- FSM=IDLE, index=0, XOR=0, timers=0.
- remote_x=0, remote_y=0, remote_state=0.
- frame_ok=0, frame_err=0, err_count=0, link_alive=0.
REQ-028 rst asserted mid-frame SHALL discard the partial frame without a frame_err pulse.
REQ-029 rst SHALL override rx_valid in the same cycle.

Structure
REQ-030 Shared package uart_frame_pkg SHALL hold:
- the HDR constant 0xA5 and FRAME_LEN=7;
- the FSM state enum;
- position width 11.
REQ-031 The transmit-side frame builder SHALL import uart_frame_pkg so both ends share one format.
REQ-032 The block SHALL be a single module with no sub-module; both timers are inline counters.

Verification
REQ-033 Good frame A5 01 23 02 AB 05 8E -> frame_ok 1 cycle after the last strobe, remote_x=0x123, remote_y=0x2AB, remote_state=0x05, link_alive=1.
REQ-034 Same frame with CHK=0x8F -> frame_err pulse, remote_* unchanged, err_count=1.
REQ-035 Range violation A5 09 23 02 AB 05 86 (checksum valid, X_HI[3]=1) -> frame_err, no update.
REQ-036 Timeout: send A5 01, then BYTE_TIMEOUT idle cycles -> frame_err, FSM IDLE. A following full good frame -> frame_ok.
REQ-037 Garbage 00 FF then A5 A5 A5 A5 A5 A5 A5 -> no error on the garbage bytes; payload of A5s with CHK 0xA5 is rejected by the range check -> frame_err.
REQ-038 Saturation and link loss:
- 300 bad frames -> err_count=255.
- Reset mid-frame -> all outputs 0, no pulse.
- No frame for LINK_TIMEOUT cycles -> link_alive=0.
